ps2_device_tx: RTL

- PS/2 device-side transmitter: emulates a keyboard driving ps2_clk and ps2_data toward the host-side receiver.
- Bytes (scan codes, e.g. make 1C, break F0 1C) are queued in an internal FIFO. Each byte is serialised as an 11-bit frame: start, 8 data bits LSB first, odd parity, stop.
- Used as the stimulus source for the keyboard receiver in simulation, and as a loopback source on the board.

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_byte_fifo.sv | 57 +++++
 rtl/ps2_device_tx.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 frame definitions for device transmitter and host receiver
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_GAP  = 2'd3
    } ps2_state_t;

    localparam int   FRAME_BITS = 11;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// rtl/ps2_byte_fifo.sv - synchronous byte FIFO with occupancy count
module ps2_byte_fifo #(
    parameter int FIFO_AW = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [7:0]         push_data,
    input  logic               pop,
    output logic [7:0]         head,
    output logic [FIFO_AW:0]   count,
    output logic               full,
    output logic               empty
);

    localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};

    logic [7:0]         mem [2**FIFO_AW];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == DEPTH);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at FIFO_AW bits; count carries the extra bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_device_tx.sv
// rtl/ps2_device_tx.sv - PS/2 device-side transmitter serialising queued bytes onto ps2_clk/ps2_data
module ps2_device_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV    = 50,
    parameter int GAP_CYCLES = 100,
    parameter int FIFO_AW    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         wr_data,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic               inhibit,
    output logic               ps2_clk,
    output logic               ps2_data,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [3:0]       STOP_IDX = 4'(FRAME_BITS - 1);

    ps2_state_t                  state;
    logic [3:0]                  bit_idx;
    logic [DIV_W-1:0]            div_cnt;
    logic [GAP_W-1:0]            gap_cnt;
    logic [FRAME_BITS-1:0]       shift;

    logic [7:0]                  fifo_head;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        push;
    logic                        pop;
    logic                        abort;
    logic [FRAME_BITS-1:0]       next_frame;
    logic [3:0]                  next_idx;

    assign wr_ready   = ~fifo_full;
    assign push       = wr_valid & wr_ready;
    assign busy       = (state != ST_IDLE);
    assign next_frame = {STOP_BIT, odd_parity(fifo_head), fifo_head, START_BIT};
    assign next_idx   = bit_idx + 4'd1;

    // The byte stays in the FIFO until its stop bit has been clocked out,
    // so an aborted frame can be resent from the start bit.
    assign pop   = (state == ST_LOW) && (bit_idx == STOP_IDX) && (div_cnt == DIV_LAST);
    assign abort = inhibit && (state == ST_HIGH || state == ST_LOW) && (bit_idx != STOP_IDX);

    ps2_byte_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (wr_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_valid && !wr_ready) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
            bit_idx  <= '0;
            div_cnt  <= '0;
            gap_cnt  <= '0;
            shift    <= '1;
        end else if (abort) begin
            state    <= ST_GAP;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
            div_cnt  <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ps2_clk  <= 1'b1;
                    ps2_data <= 1'b1;
                    if (!fifo_empty && !inhibit) begin
                        shift    <= next_frame;
                        bit_idx  <= '0;
                        div_cnt  <= '0;
                        ps2_data <= next_frame[0];
                        state    <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        ps2_clk <= 1'b0;
                        state   <= ST_LOW;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_LOW: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        ps2_clk <= 1'b1;
                        if (bit_idx == STOP_IDX) begin
                            ps2_data <= 1'b1;
                            gap_cnt  <= '0;
                            state    <= ST_GAP;
                        end else begin
                            bit_idx  <= next_idx;
                            ps2_data <= shift[next_idx];
                            state    <= ST_HIGH;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    ps2_clk  <= 1'b1;
                    ps2_data <= 1'b1;
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
